// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper phase controller.
package stepper_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
endpackage

// File: rtl/johnson_shift_bidir.sv
// Bidirectional N-bit Johnson register; clear and step are synchronous, reset is async.
module johnson_shift_bidir
  import stepper_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      if (dir == DIR_REV) q <= {q[N-2:0], ~q[N-1]};
      else                q <= {~q[0], q[N-1:1]};
    end
  end

endmodule

// File: rtl/stepper_phase_ctrl.sv
// Move sequencer: latches a step request and walks the Johnson phase one position
// every period+1 cycles, with abort, homing and a completion pulse.
//
// state   | meaning
// IDLE    | holding phase; accepts start (or home when no start)
// RUN     | move in progress; prescaler counts down, steps on terminal count
module stepper_phase_ctrl
  import stepper_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             abort,
  input  logic             home,
  output logic [N-1:0]     phase,
  output logic             busy,
  output logic             done,
  output logic             step_stb,
  output logic [CNT_W-1:0] steps_left,
  output logic             aborted
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_t           state, state_n;
  logic [DIV_W-1:0] prescaler, prescaler_n;
  logic [DIV_W-1:0] period_q, period_n;
  logic             dir_q, dir_n;
  logic             busy_n, done_n, stb_n, aborted_n;
  logic [CNT_W-1:0] left_n;
  logic             sh_clr, sh_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prescaler  <= '0;
      period_q   <= '0;
      dir_q      <= DIR_FWD;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_stb   <= 1'b0;
      steps_left <= '0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      prescaler  <= prescaler_n;
      period_q   <= period_n;
      dir_q      <= dir_n;
      busy       <= busy_n;
      done       <= done_n;
      step_stb   <= stb_n;
      steps_left <= left_n;
      aborted    <= aborted_n;
    end
  end

  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    period_n    = period_q;
    dir_n       = dir_q;
    busy_n      = busy;
    done_n      = 1'b0;
    stb_n       = 1'b0;
    left_n      = steps_left;
    aborted_n   = aborted;
    sh_clr      = 1'b0;
    sh_en       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          aborted_n = 1'b0;
          if (steps != '0) begin
            dir_n       = dir;
            period_n    = period;
            left_n      = steps;
            prescaler_n = period;
            busy_n      = 1'b1;
            state_n     = ST_RUN;
          end else begin
            done_n = 1'b1;
          end
        end else if (home) begin
          sh_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_n   = ST_IDLE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          aborted_n = 1'b1;
        end else if (prescaler != '0) begin
          prescaler_n = prescaler - DIV_ONE;
        end else begin
          sh_en       = 1'b1;
          stb_n       = 1'b1;
          left_n      = steps_left - CNT_ONE;
          prescaler_n = period_q;
          // Last step leaves RUN on the same edge that presents it.
          if (steps_left == CNT_ONE) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  johnson_shift_bidir #(.N(N)) u_phase (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .dir (dir_q),
    .q   (phase)
  );

endmodule

// File: tb/tb_stepper_phase_ctrl.sv
// Directed bench for stepper_phase_ctrl with a scoreboard of expected step events.
module tb_stepper_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, dir = 1'b0, abort = 1'b0, home = 1'b0;
  logic [15:0] steps = '0, period = '0;
  logic [3:0]  phase;
  logic        busy, done, step_stb, aborted;
  logic [15:0] steps_left;

  stepper_phase_ctrl #(.N(4), .CNT_W(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps), .period(period),
    .abort(abort), .home(home), .phase(phase), .busy(busy), .done(done),
    .step_stb(step_stb), .steps_left(steps_left), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ph;
    logic [15:0] left;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;
  logic [3:0] model_ph = 4'b0000;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] fwd(input logic [3:0] q);
    return {~q[0], q[3:1]};
  endfunction

  function automatic logic [3:0] rev(input logic [3:0] q);
    return {q[2:0], ~q[3]};
  endfunction

  // Every strobe must match the next scoreboard entry: phase, remaining count and edge.
  always @(negedge clk) begin
    if (rst) begin
      if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
      if (step_stb) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("stb_phase", 32'(phase), 32'(e.ph));
          chk("stb_left", 32'(steps_left), 32'(e.left));
          chk("stb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic queue_steps(input logic d, input int n, input int p, input int e0);
    for (int k = 1; k <= n; k++) begin
      model_ph = d ? rev(model_ph) : fwd(model_ph);
      sbq.push_back('{model_ph, 16'(n - k), e0 + k * (p + 1)});
    end
  endtask

  // g >= 0: during the move, pulse start/home with altered inputs at busy cycle g.
  task automatic do_move(input logic d, input int n, input int p, input int g);
    int cnt, e0;
    @(negedge clk);
    start = 1'b1; dir = d; steps = 16'(n); period = 16'(p);
    e0 = cyc + 1;
    queue_steps(d, n, p, e0);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_phase", 32'(phase), 32'(model_ph));
      chk("zero_aborted", 32'(aborted), 32'd0);
      @(negedge clk);
      chk("zero_done_drop", 32'(done), 32'd0);
      return;
    end
    cnt = 0;
    while (busy && cnt < n * (p + 1) + 20) begin
      cnt++;
      if (cnt == g) begin
        start = 1'b1; home = 1'b1; steps = 16'd7; dir = ~d; period = 16'd0;
      end else begin
        start = 1'b0; home = 1'b0; steps = 16'(n); dir = d; period = 16'(p);
      end
      @(negedge clk);
    end
    start = 1'b0; home = 1'b0;
    chk("busy_len", 32'(cnt), 32'(n * (p + 1)));
    chk("end_done", 32'(done), 32'd1);
    chk("end_phase", 32'(phase), 32'(model_ph));
    chk("end_left", 32'(steps_left), 32'd0);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int e0;
    repeat (2) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stb", 32'(step_stb), 32'd0);
    chk("rst_left", 32'(steps_left), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rst = 1'b1;

    do_move(1'b0, 3, 0, -1);
    chk("fwd3_phase", 32'(phase), 32'b1110);

    @(negedge clk); home = 1'b1;
    @(negedge clk); home = 1'b0;
    model_ph = 4'b0000;
    chk("home_idle", 32'(phase), 32'd0);

    do_move(1'b0, 8, 1, -1);
    do_move(1'b1, 2, 0, -1);
    chk("rev2_phase", 32'(phase), 32'b0011);
    do_move(1'b0, 2, 0, -1);
    chk("fwd2_phase", 32'(phase), 32'b0000);

    // Abort sampled at E6 of a 10-step, period-3 move: one step at E4 only.
    @(negedge clk);
    start = 1'b1; dir = 1'b0; steps = 16'd10; period = 16'd3;
    e0 = cyc + 1;
    model_ph = fwd(model_ph);
    sbq.push_back('{model_ph, 16'd9, e0 + 4});
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_left", 32'(steps_left), 32'd9);
    chk("abort_phase", 32'(phase), 32'b1000);
    chk("abort_sb", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    chk("abort_done_width", 32'(done), 32'd0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle_ignored", 32'(done), 32'd0);

    do_move(1'b0, 0, 0, -1);
    chk("zero_phase_hold", 32'(phase), 32'b1000);

    do_move(1'b0, 4, 1, 3);

    // Asynchronous reset in the middle of a move.
    @(negedge clk);
    start = 1'b1; dir = 1'b1; steps = 16'd5; period = 16'd2;
    e0 = cyc + 1;
    queue_steps(1'b1, 5, 2, e0);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_left", 32'(steps_left), 32'd0);
    chk("arst_all", 32'({done, step_stb, aborted}), 32'd0);
    sbq.delete();
    model_ph = 4'b0000;
    @(negedge clk); rst = 1'b1;

    do_move(1'b0, 3, 0, -1);
    @(negedge clk); home = 1'b1;
    @(negedge clk); home = 1'b0;
    model_ph = 4'b0000;
    chk("home_1110", 32'(phase), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stepper_phase_ctrl.md
# stepper_phase_ctrl

Sequencer for an N-bit bidirectional Johnson phase register that drives stepper/phase outputs. On a start command it latches a step count, step period and direction. It then advances the Johnson pattern one position every period+1 cycles, flags completion, and supports abort and homing. It sits between the motion/command logic and the phase drivers, and holds the current phase between moves.

## Interface
- N, 4: phase width; Johnson sequence length is 2N
- CNT_W, 16: step-count width
- DIV_W, 16: step-period width
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  move request, sampled in IDLE only
- dir  input  1  0 = forward, 1 = reverse; latched at start
- steps  input  CNT_W  number of steps to perform; latched at start
- period  input  DIV_W  step interval minus one, in cycles; latched at start
- abort  input  1  terminate the move, effective in RUN only
- home  input  1  clear phase to all-zero, effective in IDLE only
- phase  output  N  current Johnson phase pattern
- busy  output  1  move in progress
- done  output  1  one-cycle pulse at the end of a move, whether completed, aborted or zero-length
- step_stb  output  1  one-cycle pulse in the cycle the new phase is presented
- steps_left  output  CNT_W  remaining steps
- aborted  output  1  last move was aborted; cleared on the next accepted start

## Operation
- Reset value of every output is 0; FSM is in IDLE.
- Forward step: phase <= {~phase[0], phase[N-1:1]}. For N=4 from reset: 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Reverse step: phase <= {phase[N-2:0], ~phase[N-1]}. This is the exact inverse of a forward step.
- Phase is only ever cleared or stepped, so it always stays in the legal 2N-state set.
- FSM states: IDLE and RUN.
- IDLE, start=1, steps≠0:
  - latch dir, period and steps; steps_left <= steps
  - prescaler <= period; busy <= 1; aborted <= 0
  - go to RUN
- IDLE, start=1, steps=0: done <= 1 for one cycle; aborted <= 0; no state change; phase unchanged.
- IDLE, home=1 with start=0: phase <= 0. If start=1 in the same cycle, start wins and home is ignored.
- RUN, per cycle:
  - abort=1: go to IDLE; busy <= 0; done <= 1; aborted <= 1. No step is taken even if the prescaler is 0. Phase and steps_left hold.
  - else if prescaler≠0: prescaler decrements.
  - else (prescaler=0): step phase; step_stb <= 1; steps_left decrements; prescaler <= period.
  - If steps_left was 1 at that step: go to IDLE; busy <= 0; done <= 1 in the same edge.
- In RUN, start, home and changes to dir/steps/period are ignored.
- abort and home are ignored in IDLE and RUN respectively.
- Reset mid-move: immediate return to IDLE; all outputs 0; the move is lost.

## Timing
- All outputs are registered.
- start is sampled at edge E0:
  - busy is high from E0.
  - Steps occur at edges E0+k·(period+1), for k = 1..steps.
  - The last step edge also drops busy and raises done.
- Busy duration is exactly steps·(period+1) cycles. period=0 gives one step per cycle.
- step_stb, the new phase value and the decremented steps_left appear together after the step edge.
- done is high for exactly one cycle. busy and done are never high together.
- The earliest restart is a start sampled on the cycle where done=1, since the FSM is already in IDLE.

## Structure
- Package stepper_pkg holds:
  - state typedef (ST_IDLE, ST_RUN)
  - direction constants DIR_FWD=1'b0, DIR_REV=1'b1
- Sub-module johnson_shift_bidir:
  - parameter N
  - ports clk, rst, clr, en, dir, q[N-1:0]
  - implements the two step equations above and synchronous clear
  - resets asynchronously to 0
- Top level holds the FSM, the prescaler, the step counter and the output flags.

## Test plan
- Reset, then start with steps=3, period=0, dir=0 → phase 1000, 1100, 1110 after E1, E2, E3; busy high 3 cycles; done pulse after E3; 3 step_stb pulses.
- steps=8, period=1, forward from 0000 → phase passes 1111 and returns to 0000; busy 16 cycles; 8 strobes spaced 2 cycles apart.
- Reverse steps=2 from 0000 → 0001, 0011. Then forward steps=2 → 0001, 0000.
- steps=10, period=3, abort sampled at E6 → single step at E4 (phase 1000); after E6 busy=0, done=1, aborted=1, steps_left=9. The next start clears aborted.
- start with steps=0 → done pulse after E0, busy never high, phase unchanged. start pulsed while busy → ignored, step total unchanged.
- rst asserted mid-move → all outputs 0 immediately, without waiting for a clock edge. Later, phase=1110 in IDLE, home=1 → phase 0000 after the next edge. home during RUN → ignored.
